// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the frame state encoding, word/address types and the checksum helper.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_H  = 3'd1,
        ST_LEN_L  = 3'd2,
        ST_DATA_H = 3'd3,
        ST_DATA_L = 3'd4,
        ST_WRITE  = 3'd5,
        ST_CSUM   = 3'd6
    } state_t;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Loads a checksummed byte-stream image into instruction memory and holds the
// CPU in reset until a complete frame has been verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter addr_t      BASE_ADDR = 16'h0000,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        pc_reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] instruction_out,
    output logic [15:0] load_address,
    output logic        load_instruction,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t     state_r;
    addr_t      addr_r;
    logic [15:0] remaining_r;
    logic [7:0] len_hi_r;
    logic [7:0] data_hi_r;
    logic [7:0] csum_r;

    logic        byte_ready_r;
    word_t       instruction_out_r;
    addr_t       load_address_r;
    logic        load_instruction_r;
    logic        cpu_hold_r;
    logic        done_r;
    logic        error_r;

    logic        accept_s;

    assign accept_s         = byte_valid && byte_ready_r;
    assign byte_ready       = byte_ready_r;
    assign instruction_out  = instruction_out_r;
    assign load_address     = load_address_r;
    assign load_instruction = load_instruction_r;
    assign cpu_hold         = cpu_hold_r;
    assign done             = done_r;
    assign error            = error_r;

    // Frame FSM with inline word assembler, counters, checksum and registered outputs
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            state_r            <= ST_IDLE;
            addr_r             <= BASE_ADDR;
            remaining_r        <= 16'h0000;
            len_hi_r           <= 8'h00;
            data_hi_r          <= 8'h00;
            csum_r             <= 8'h00;
            byte_ready_r       <= 1'b1;
            instruction_out_r  <= 16'h0000;
            load_address_r     <= BASE_ADDR;
            load_instruction_r <= 1'b0;
            cpu_hold_r         <= 1'b1;
            done_r             <= 1'b0;
            error_r            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (byte_in == SYNC_BYTE)) begin
                        state_r    <= ST_LEN_H;
                        cpu_hold_r <= 1'b1;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        csum_r     <= 8'h00;
                        addr_r     <= BASE_ADDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LEN_H: begin
                    if (accept_s) begin
                        len_hi_r <= byte_in;
                        csum_r   <= csum_next(csum_r, byte_in);
                        state_r  <= ST_LEN_L;
                    end else begin
                        state_r <= ST_LEN_H;
                    end
                end
                ST_LEN_L: begin
                    if (accept_s) begin
                        remaining_r <= {len_hi_r, byte_in};
                        csum_r      <= csum_next(csum_r, byte_in);
                        if ({len_hi_r, byte_in} == 16'h0000) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA_H;
                        end
                    end else begin
                        state_r <= ST_LEN_L;
                    end
                end
                ST_DATA_H: begin
                    if (accept_s) begin
                        data_hi_r <= byte_in;
                        csum_r    <= csum_next(csum_r, byte_in);
                        state_r   <= ST_DATA_L;
                    end else begin
                        state_r <= ST_DATA_H;
                    end
                end
                ST_DATA_L: begin
                    // Present the word on the write port next cycle and pause input for it
                    if (accept_s) begin
                        csum_r             <= csum_next(csum_r, byte_in);
                        instruction_out_r  <= {data_hi_r, byte_in};
                        load_address_r     <= addr_r;
                        load_instruction_r <= 1'b1;
                        byte_ready_r       <= 1'b0;
                        state_r            <= ST_WRITE;
                    end else begin
                        state_r <= ST_DATA_L;
                    end
                end
                ST_WRITE: begin
                    load_instruction_r <= 1'b0;
                    byte_ready_r       <= 1'b1;
                    addr_r             <= addr_r + 16'd1;
                    remaining_r        <= remaining_r - 16'd1;
                    if (remaining_r == 16'd1) begin
                        state_r <= ST_CSUM;
                    end else begin
                        state_r <= ST_DATA_H;
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        if (byte_in == csum_r) begin
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            error_r    <= 1'b1;
                            cpu_hold_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CSUM;
                    end
                end
                default: begin
                    state_r            <= ST_IDLE;
                    byte_ready_r       <= 1'b1;
                    load_instruction_r <= 1'b0;
                    cpu_hold_r         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: one default-base instance
// and one instance with BASE_ADDR at the top of memory for the wrap case.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        pc_reset = 1'b1;

    logic [7:0]  byte_in_a = 8'h00;
    logic        byte_valid_a = 1'b0;
    logic        byte_ready_a;
    logic [15:0] instruction_out_a;
    logic [15:0] load_address_a;
    logic        load_instruction_a;
    logic        cpu_hold_a;
    logic        done_a;
    logic        error_a;

    logic [7:0]  byte_in_b = 8'h00;
    logic        byte_valid_b = 1'b0;
    logic        byte_ready_b;
    logic [15:0] instruction_out_b;
    logic [15:0] load_address_b;
    logic        load_instruction_b;
    logic        cpu_hold_b;
    logic        done_b;
    logic        error_b;

    int checks = 0;
    int failures = 0;

    logic [15:0] qa_addr[$];
    logic [15:0] qa_data[$];
    logic [15:0] qb_addr[$];
    logic [15:0] qb_data[$];

    always #5 clk = ~clk;

    program_loader dut_a (
        .clk              (clk),
        .pc_reset         (pc_reset),
        .byte_in          (byte_in_a),
        .byte_valid       (byte_valid_a),
        .byte_ready       (byte_ready_a),
        .instruction_out  (instruction_out_a),
        .load_address     (load_address_a),
        .load_instruction (load_instruction_a),
        .cpu_hold         (cpu_hold_a),
        .done             (done_a),
        .error            (error_a)
    );

    program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
        .clk              (clk),
        .pc_reset         (pc_reset),
        .byte_in          (byte_in_b),
        .byte_valid       (byte_valid_b),
        .byte_ready       (byte_ready_b),
        .instruction_out  (instruction_out_b),
        .load_address     (load_address_b),
        .load_instruction (load_instruction_b),
        .cpu_hold         (cpu_hold_b),
        .done             (done_b),
        .error            (error_b)
    );

    // Log every strobe cycle; a strobe longer than one cycle shows up as an extra entry
    always @(negedge clk) begin
        if (load_instruction_a === 1'b1) begin
            qa_addr.push_back(load_address_a);
            qa_data.push_back(instruction_out_a);
        end
        if (load_instruction_b === 1'b1) begin
            qb_addr.push_back(load_address_b);
            qb_data.push_back(instruction_out_b);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit to_b);
        logic r;
        bit ok;
        ok = 1'b0;
        if (to_b) begin
            byte_in_b = b;
            byte_valid_b = 1'b1;
        end else begin
            byte_in_a = b;
            byte_valid_a = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = to_b ? byte_ready_b : byte_ready_a;
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL handshake_timeout byte=%h got no ready, required ready within 50 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        byte_valid_a = 1'b0;
        byte_valid_b = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        idle(10);
        checks++;
        if (cpu_hold_a !== 1'b1 || done_a !== 1'b0 || error_a !== 1'b0 || byte_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags got hold=%b done=%b err=%b rdy=%b required 1 0 0 1",
                     cpu_hold_a, done_a, error_a, byte_ready_a);
        end
        checks++;
        if (load_address_a !== 16'h0000 || instruction_out_a !== 16'h0000) begin
            failures++;
            $display("FAIL reset_port got addr=%h data=%h required 0000 0000", load_address_a, instruction_out_a);
        end
        checks++;
        if (load_address_b !== 16'hFFFF || cpu_hold_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_base_b got addr=%h hold=%b required ffff 1", load_address_b, cpu_hold_b);
        end
        checks++;
        if (qa_addr.size() != 0 || qb_addr.size() != 0) begin
            failures++;
            $display("FAIL reset_no_strobe got %0d/%0d strobes required 0", qa_addr.size(), qb_addr.size());
        end
    endtask

    task automatic test_good_frame;
        qa_addr.delete();
        qa_data.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        checks++;
        if (load_instruction_a !== 1'b1 || load_address_a !== 16'h0000 ||
            instruction_out_a !== 16'h1234 || byte_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL write_latency got li=%b addr=%h data=%h rdy=%b required 1 0000 1234 0",
                     load_instruction_a, load_address_a, instruction_out_a, byte_ready_a);
        end
        @(posedge clk);
        #1;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        checks++;
        if (done_a !== 1'b0 || cpu_hold_a !== 1'b1) begin
            failures++;
            $display("FAIL pre_csum got done=%b hold=%b required 0 1", done_a, cpu_hold_a);
        end
        send_byte(8'h42, 1'b0);
        checks++;
        if (done_a !== 1'b1 || cpu_hold_a !== 1'b0 || error_a !== 1'b0) begin
            failures++;
            $display("FAIL good_done got done=%b hold=%b err=%b required 1 0 0", done_a, cpu_hold_a, error_a);
        end
        idle(3);
        checks++;
        if (qa_addr.size() != 2) begin
            failures++;
            $display("FAIL good_strobes got %0d strobes required 2", qa_addr.size());
        end else if (qa_addr[0] !== 16'h0000 || qa_data[0] !== 16'h1234 ||
                     qa_addr[1] !== 16'h0001 || qa_data[1] !== 16'hABCD) begin
            failures++;
            $display("FAIL good_words got %h:%h %h:%h required 0000:1234 0001:abcd",
                     qa_addr[0], qa_data[0], qa_addr[1], qa_data[1]);
        end
    endtask

    task automatic test_bad_csum;
        qa_addr.delete();
        qa_data.delete();
        send_byte(8'hA5, 1'b0);
        checks++;
        if (cpu_hold_a !== 1'b1 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reload_hold got hold=%b done=%b required 1 0", cpu_hold_a, done_a);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h43, 1'b0);
        checks++;
        if (error_a !== 1'b1 || done_a !== 1'b0 || cpu_hold_a !== 1'b1) begin
            failures++;
            $display("FAIL bad_csum got err=%b done=%b hold=%b required 1 0 1", error_a, done_a, cpu_hold_a);
        end
        idle(3);
        checks++;
        if (qa_addr.size() != 2) begin
            failures++;
            $display("FAIL bad_strobes got %0d strobes required 2", qa_addr.size());
        end else if (qa_data[0] !== 16'h1234 || qa_data[1] !== 16'hABCD) begin
            failures++;
            $display("FAIL bad_words got %h %h required 1234 abcd", qa_data[0], qa_data[1]);
        end
    endtask

    task automatic test_garbage_empty;
        logic [7:0] seq [7];
        qa_addr.delete();
        qa_data.delete();
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) send_byte(seq[i], 1'b0);
        checks++;
        if (done_a !== 1'b1 || error_a !== 1'b0 || cpu_hold_a !== 1'b0) begin
            failures++;
            $display("FAIL empty_frame got done=%b err=%b hold=%b required 1 0 0", done_a, error_a, cpu_hold_a);
        end
        idle(3);
        checks++;
        if (qa_addr.size() != 0 || load_address_a !== 16'h0001 || instruction_out_a !== 16'hABCD) begin
            failures++;
            $display("FAIL empty_hold got strobes=%0d addr=%h data=%h required 0 0001 abcd",
                     qa_addr.size(), load_address_a, instruction_out_a);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] seq [8];
        seq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1);
        checks++;
        if (done_b !== 1'b1 || cpu_hold_b !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done got done=%b hold=%b required 1 0", done_b, cpu_hold_b);
        end
        idle(3);
        checks++;
        if (qb_addr.size() != 2) begin
            failures++;
            $display("FAIL wrap_strobes got %0d strobes required 2", qb_addr.size());
        end else if (qb_addr[0] !== 16'hFFFF || qb_data[0] !== 16'h0001 ||
                     qb_addr[1] !== 16'h0000 || qb_data[1] !== 16'h0002) begin
            failures++;
            $display("FAIL wrap_words got %h:%h %h:%h required ffff:0001 0000:0002",
                     qb_addr[0], qb_data[0], qb_addr[1], qb_data[1]);
        end
    endtask

    task automatic test_gaps_reset;
        logic [7:0] seq [10];
        send_byte(8'hA5, 1'b0); idle($urandom_range(0, 3));
        send_byte(8'h00, 1'b0); idle($urandom_range(0, 3));
        send_byte(8'h02, 1'b0); idle($urandom_range(0, 3));
        send_byte(8'h12, 1'b0); idle($urandom_range(0, 3));
        send_byte(8'h34, 1'b0);
        byte_valid_a = 1'b0;
        checks++;
        if (load_instruction_a !== 1'b1 || instruction_out_a !== 16'h1234) begin
            failures++;
            $display("FAIL gap_write got li=%b data=%h required 1 1234", load_instruction_a, instruction_out_a);
        end
        #1 pc_reset = 1'b1;
        #1;
        checks++;
        if (load_instruction_a !== 1'b0 || cpu_hold_a !== 1'b1 || byte_ready_a !== 1'b1 ||
            done_a !== 1'b0 || error_a !== 1'b0 || load_address_a !== 16'h0000 ||
            instruction_out_a !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset got li=%b hold=%b rdy=%b done=%b err=%b addr=%h data=%h required 0 1 1 0 0 0000 0000",
                     load_instruction_a, cpu_hold_a, byte_ready_a, done_a, error_a,
                     load_address_a, instruction_out_a);
        end
        @(posedge clk);
        #1 pc_reset = 1'b0;
        qa_addr.delete();
        qa_data.delete();
        seq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h03};
        for (int i = 0; i < 10; i++) begin
            send_byte(seq[i], 1'b0);
            idle($urandom_range(0, 3));
        end
        checks++;
        if (done_a !== 1'b1 || cpu_hold_a !== 1'b0 || error_a !== 1'b0) begin
            failures++;
            $display("FAIL reload_done got done=%b hold=%b err=%b required 1 0 0", done_a, cpu_hold_a, error_a);
        end
        checks++;
        if (qa_addr.size() != 3) begin
            failures++;
            $display("FAIL reload_strobes got %0d strobes required 3", qa_addr.size());
        end else if (qa_addr[0] !== 16'h0000 || qa_data[0] !== 16'h1111 ||
                     qa_addr[1] !== 16'h0001 || qa_data[1] !== 16'h2222 ||
                     qa_addr[2] !== 16'h0002 || qa_data[2] !== 16'h3333) begin
            failures++;
            $display("FAIL reload_words got %h:%h %h:%h %h:%h required 0000:1111 0001:2222 0002:3333",
                     qa_addr[0], qa_data[0], qa_addr[1], qa_data[1], qa_addr[2], qa_data[2]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 pc_reset = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_garbage_empty();
        test_wrap();
        test_gaps_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
